decoder_nscan: RTL and testbench
================================

// Module: decoder_nscan
// PURPOSE
//  Parametrised registered N-to-2^N binary-to-one-hot decoder with enable gating,
//  valid/ready handshake on both sides and a self-driven scan mode. Scan mode steps
//  through every code with a programmable dwell. Generalises the 2-to-4 enable
//  decoder for use as a select/strobe generator in clocked datapaths.
// PARAMETERS
//  N        2   code width; 1..6; output width is 2**N
//  DWELL    0   idle cycles between scan beats; 0..255; 0 = back-to-back beats
//  DWELL_W  8   width of the dwell down-counter; must satisfy DWELL < 2**DWELL_W
// PORTS
//  clk         in   1      clock; all state changes on rising edge
//  rst         in   1      synchronous reset, active-high
//  en          in   1      enable: gates one-hot output (decode); pauses scan (scan)
//  mode        in   1      0 = decode input codes, 1 = internal scan
//  in_valid    in   1      in_code valid
//  in_ready    out  1      block can accept in_code this cycle
//  in_code     in   N      binary code to decode
//  out_valid   out  1      output beat valid
//  out_ready   in   1      downstream accepts beat
//  out_onehot  out  2**N   one-hot decode (all-zero if en was 0 at load)
//  out_code    out  N      binary code of current beat
//  scan_wrap   out  1      high with the scan beat carrying code 2**N-1
// BEHAVIOUR
//  Reset: state=DEC, out_valid=0, out_onehot=0, out_code=0, scan_wrap=0,
//   scan count=0, dwell count=0. rst has priority over all events at the same edge;
//   an in-flight beat is discarded and never re-presented.
//  Output register:
//   - slot_free = !out_valid || out_ready.
//   - While out_valid && !out_ready: out_onehot, out_code and scan_wrap hold stable.
//   - A beat is consumed on out_valid && out_ready.
//   - out_valid drops next cycle unless a new beat loads at the same edge.
//  Load rule (both modes): out_code<=code; out_onehot<=en ? (1<<code) : 0.
//  States DEC, SCAN_EMIT, SCAN_DWELL:
//   DEC:
//    - in_ready = slot_free && !mode.
//    - Accept on in_valid && in_ready; load at that edge, so out_valid=1 next cycle
//      (latency 1). Full throughput with out_ready=1.
//    - scan_wrap=0 for every decode beat.
//    - mode=1 -> SCAN_EMIT with scan count=0; nothing is accepted that cycle.
//   SCAN_EMIT:
//    - in_ready=0.
//    - mode=0 -> DEC.
//    - en=0 -> stay; no emission.
//    - slot_free && en -> load scan count; out_onehot is non-zero.
//      scan_wrap <= (count==2**N-1).
//      Count increments, wrapping 2**N-1 -> 0.
//      If DWELL>0, go to SCAN_DWELL with dwell count=DWELL; else stay.
//   SCAN_DWELL:
//    - in_ready=0.
//    - mode=0 -> DEC immediately; remaining dwell and scan count are abandoned.
//    - en=0 freezes the dwell count.
//    - Otherwise decrement; at dwell count 1 -> SCAN_EMIT.
//    - Minimum beat spacing is DWELL+1 cycles. Backpressure stretches spacing,
//      never skips a code.
//  Re-entering scan mode always restarts at code 0.
//  A beat already in the output register when mode changes stays until consumed.
//  No combinational path from in_valid/in_code to any output.
//  in_ready depends combinationally on out_ready, mode and state.
// TESTING
//  T1 N=2, en=1, out_ready=1, decode codes 0,1,2,3 back-to-back:
//     out_onehot 0001,0010,0100,1000 each one cycle after accept; out_valid held 1.
//  T2 en=0, code 2: beat has out_onehot=0000, out_code=2, scan_wrap=0.
//  T3 beat code 1 issued, then out_ready=0 for 3 cycles with code 3 offered:
//     in_ready=0 and out_onehot=0010 held; one cycle after release, onehot=1000.
//  T4 N=2, DWELL=2, out_ready=1, mode=1: beats 0,1,2,3,0 spaced 3 cycles apart;
//     scan_wrap=1 only with the code-3 beat; en=0 for 2 cycles adds 2 cycles of spacing.
//  T5 rst pulsed mid-scan while code-2 beat is stalled:
//     next cycle out_valid=0, out_onehot=0; with mode=1 the first new beat is code 0.
//  T6 mode 1->0 during SCAN_DWELL: no further scan beats.
//     After the pending beat drains, in_ready=1 and decode code 1 gives 0010.

Source files
------------

// File: rtl/decoder_nscan.sv
// Registered N-to-2**N one-hot decoder with enable gating, valid/ready on both
// sides and a self-driven scan mode that steps all codes with a fixed dwell.
module decoder_nscan #(
   parameter int N       = 2,
   parameter int DWELL   = 0,
   parameter int DWELL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N-1:0]      in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2**N-1:0]   out_onehot,
   output logic [N-1:0]      out_code,
   output logic              scan_wrap
);

   localparam int W = 2**N;
   localparam logic [N-1:0] CODE_MAX = '1;
   localparam logic [DWELL_W-1:0] DW = DWELL_W'(DWELL);
   localparam logic [W-1:0] ONE = W'(1);

   typedef enum logic [1:0] {
      DEC,
      SCAN_EMIT,
      SCAN_DWELL
   } state_t;

   state_t state;
   state_t state_nx;

   logic [N-1:0]       scan_cnt;
   logic [DWELL_W-1:0] dwell_cnt;
   logic               slot_free;
   logic               load;
   logic               scan_load;
   logic [N-1:0]       load_code;
   logic               load_wrap;

   assign slot_free = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= DEC;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         DEC: begin
            if (mode) state_nx = SCAN_EMIT;
         end
         SCAN_EMIT: begin
            if (!mode)
               state_nx = DEC;
            else if (scan_load && DWELL > 0)
               state_nx = SCAN_DWELL;
         end
         SCAN_DWELL: begin
            if (!mode)
               state_nx = DEC;
            else if (en && dwell_cnt <= DWELL_W'(1))
               state_nx = SCAN_EMIT;
         end
         default: state_nx = DEC;
      endcase
   end

   // in_ready never looks at in_valid/in_code, so no input-to-output path
   always_comb begin
      in_ready  = 1'b0;
      load      = 1'b0;
      scan_load = 1'b0;
      load_code = in_code;
      load_wrap = 1'b0;
      unique case (state)
         DEC: begin
            in_ready = slot_free && !mode;
            load     = in_valid && in_ready;
         end
         SCAN_EMIT: begin
            scan_load = mode && en && slot_free;
            load      = scan_load;
            load_code = scan_cnt;
            load_wrap = (scan_cnt == CODE_MAX);
         end
         SCAN_DWELL: begin
            in_ready = 1'b0;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt  <= '0;
         dwell_cnt <= '0;
      end else begin
         if (state == DEC && mode)
            scan_cnt <= '0;
         else if (scan_load)
            scan_cnt <= scan_cnt + 1'b1;

         if (scan_load)
            dwell_cnt <= DW;
         else if (state == SCAN_DWELL && mode && en)
            dwell_cnt <= dwell_cnt - 1'b1;
      end
   end

   // Data fields hold after consumption; only out_valid marks a live beat
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_onehot <= '0;
         out_code   <= '0;
         scan_wrap  <= 1'b0;
      end else if (load) begin
         out_valid  <= 1'b1;
         out_code   <= load_code;
         out_onehot <= en ? (ONE << load_code) : '0;
         scan_wrap  <= load_wrap;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decoder_nscan.sv
// Directed bench for decoder_nscan: vector tables for decode/stall/reset/mode
// cases plus a hand-written scan spacing sequence.
module tb_decoder_nscan;

   localparam int N = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         mode;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_code;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   out_onehot;
   logic [N-1:0] out_code;
   logic         scan_wrap;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   decoder_nscan #(.N(N), .DWELL(2), .DWELL_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_onehot(out_onehot), .out_code(out_code), .scan_wrap(scan_wrap)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic       r, e, m, iv;
      logic [1:0] c;
      logic       ordy;
      logic       chk_rdy, rdy;
      logic       ov;
      logic       chk_dat;
      logic [3:0] oh;
      logic [1:0] oc;
      logic       w;
   } vec_t;

   function automatic vec_t v(input logic r, e, m, iv,
                              input logic [1:0] c, input logic ordy,
                              input logic cr, rdy, ov, cd,
                              input logic [3:0] oh, input logic [1:0] oc,
                              input logic w);
      vec_t x;
      x.r = r; x.e = e; x.m = m; x.iv = iv; x.c = c; x.ordy = ordy;
      x.chk_rdy = cr; x.rdy = rdy; x.ov = ov; x.chk_dat = cd;
      x.oh = oh; x.oc = oc; x.w = w;
      return x;
   endfunction

   task automatic check(input string nm, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic run_vec(input string nm, input int idx, input vec_t x);
      @(negedge clk);
      rst = x.r; en = x.e; mode = x.m; in_valid = x.iv;
      in_code = x.c; out_ready = x.ordy;
      #1;
      if (x.chk_rdy) check({nm, ".in_ready"}, idx, in_ready, x.rdy);
      @(posedge clk);
      #1;
      check({nm, ".out_valid"}, idx, out_valid, x.ov);
      if (x.chk_dat) begin
         check({nm, ".onehot"}, idx, out_onehot, x.oh);
         check({nm, ".code"}, idx, out_code, x.oc);
         check({nm, ".wrap"}, idx, scan_wrap, x.w);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t t1[$];
   vec_t t2[$];

   initial begin
      logic [1:0] scan_codes [5];
      int last;
      int nb;
      int found;

      rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0;
      in_code = '0; out_ready = 1'b1;

      // reset, T1 back-to-back decode, T2 enable gating, T3 backpressure
      t1.push_back(v(1,1,0,0,0,1, 0,0, 0,1,4'b0000,0,0));
      t1.push_back(v(0,1,0,1,0,1, 1,1, 1,1,4'b0001,0,0));
      t1.push_back(v(0,1,0,1,1,1, 1,1, 1,1,4'b0010,1,0));
      t1.push_back(v(0,1,0,1,2,1, 1,1, 1,1,4'b0100,2,0));
      t1.push_back(v(0,1,0,1,3,1, 1,1, 1,1,4'b1000,3,0));
      t1.push_back(v(0,1,0,0,0,1, 1,1, 0,0,4'b0000,0,0));
      t1.push_back(v(0,0,0,1,2,1, 1,1, 1,1,4'b0000,2,0));
      t1.push_back(v(0,1,0,0,0,1, 1,1, 0,0,4'b0000,0,0));
      t1.push_back(v(0,1,0,1,1,1, 1,1, 1,1,4'b0010,1,0));
      t1.push_back(v(0,1,0,1,3,0, 1,0, 1,1,4'b0010,1,0));
      t1.push_back(v(0,1,0,1,3,0, 1,0, 1,1,4'b0010,1,0));
      t1.push_back(v(0,1,0,1,3,0, 1,0, 1,1,4'b0010,1,0));
      t1.push_back(v(0,1,0,1,3,1, 1,1, 1,1,4'b1000,3,0));
      t1.push_back(v(0,1,0,0,0,1, 1,1, 0,0,4'b0000,0,0));

      // T5 reset while code-2 scan beat stalls, T6 mode drop in dwell
      t2.push_back(v(1,1,1,0,0,1, 0,0, 0,1,4'b0000,0,0));
      t2.push_back(v(0,1,1,0,0,1, 1,0, 0,0,4'b0000,0,0));
      t2.push_back(v(0,1,1,0,0,1, 1,0, 1,1,4'b0001,0,0));
      t2.push_back(v(0,1,1,0,0,1, 1,0, 0,0,4'b0000,0,0));
      t2.push_back(v(0,1,1,0,0,1, 1,0, 0,0,4'b0000,0,0));
      t2.push_back(v(0,1,1,0,0,1, 1,0, 1,1,4'b0010,1,0));
      t2.push_back(v(0,1,1,0,0,1, 1,0, 0,0,4'b0000,0,0));
      t2.push_back(v(0,1,1,0,0,0, 1,0, 0,0,4'b0000,0,0));
      t2.push_back(v(0,1,1,0,0,0, 1,0, 1,1,4'b0100,2,0));
      t2.push_back(v(0,1,1,0,0,0, 1,0, 1,1,4'b0100,2,0));
      t2.push_back(v(1,1,1,0,0,0, 1,0, 0,1,4'b0000,0,0));
      t2.push_back(v(0,1,1,0,0,1, 1,0, 0,0,4'b0000,0,0));
      t2.push_back(v(0,1,1,0,0,1, 1,0, 1,1,4'b0001,0,0));
      t2.push_back(v(0,1,0,0,0,0, 1,0, 1,1,4'b0001,0,0));
      t2.push_back(v(0,1,0,1,1,0, 1,0, 1,1,4'b0001,0,0));
      t2.push_back(v(0,1,0,1,1,1, 1,1, 1,1,4'b0010,1,0));
      t2.push_back(v(0,1,0,0,0,1, 1,1, 0,0,4'b0000,0,0));
      t2.push_back(v(0,1,0,0,0,1, 1,1, 0,0,4'b0000,0,0));

      foreach (t1[i]) run_vec("dec", i, t1[i]);

      // T4: scan beats 0,1,2,3,0 spaced DWELL+1 = 3 cycles
      scan_codes[0] = 2'd0; scan_codes[1] = 2'd1; scan_codes[2] = 2'd2;
      scan_codes[3] = 2'd3; scan_codes[4] = 2'd0;
      mode = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      last = 0;
      nb = 0;
      for (int c = 0; c < 40 && nb < 5; c++) begin
         tick();
         if (out_valid) begin
            check("scan.code", nb, out_code, scan_codes[nb]);
            check("scan.onehot", nb, out_onehot, 4'b0001 << scan_codes[nb]);
            check("scan.wrap", nb, scan_wrap, (nb == 3) ? 1 : 0);
            if (nb > 0) check("scan.spacing", nb, cyc - last, 3);
            last = cyc;
            nb++;
         end
      end
      if (nb < 5) begin
         tests++; fails++;
         $display("FAIL scan.timeout: got %0d beats expected 5", nb);
      end

      // en=0 for two dwell cycles stretches the next spacing to 5
      en = 1'b0;
      tick();
      tick();
      en = 1'b1;
      found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
         tick();
         if (out_valid) begin
            found = 1;
            check("pause.code", 0, out_code, 1);
            check("pause.onehot", 0, out_onehot, 4'b0010);
            check("pause.wrap", 0, scan_wrap, 0);
            check("pause.spacing", 0, cyc - last, 5);
         end
      end
      if (found == 0) begin
         tests++; fails++;
         $display("FAIL pause.timeout: got no beat expected code 1");
      end

      foreach (t2[i]) run_vec("scan_rst", i, t2[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
